// File: rtl/i2c_temp_monitor.sv
// i2c_temp_monitor: periodically requests a 16-bit LM75 word from the i2c read
// master, converts it to a signed 9-bit temperature (0.5C/LSB), tracks min/max,
// and drives a hysteresis alarm plus a level interrupt. The registers are
// decoded on addr_i[19:16].
module i2c_temp_monitor #(
    parameter int unsigned PERIOD_CYCLES  = 50_000_000,
    parameter int unsigned TIMEOUT_CYCLES = 2_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        i2c_req_o,
    input  logic [15:0] i2c_data_i,
    input  logic        i2c_ready_i,
    output logic        int_o
);

    localparam logic [3:0] REG_CTRL  = 4'd1;
    localparam logic [3:0] REG_STAT  = 4'd2;
    localparam logic [3:0] REG_TEMP  = 4'd3;
    localparam logic [3:0] REG_THIGH = 4'd4;
    localparam logic [3:0] REG_TLOW  = 4'd5;
    localparam logic [3:0] REG_MNMX  = 4'd6;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_REQ,
        S_BUSY,
        S_UPD
    } state_t;

    state_t            state;
    logic [31:0]       cnt;
    logic              ready_q;
    logic              rise;

    logic              ctrl_en;
    logic              ctrl_oneshot;
    logic              ctrl_int_en;
    logic              en_nx;
    logic              oneshot_nx;
    logic              int_en_nx;

    logic              stat_alarm;
    logic              stat_evt;
    logic              stat_tmo;
    logic              stat_valid;
    logic              busy;

    logic signed [8:0] temp;
    logic signed [8:0] thigh;
    logic signed [8:0] tlow;
    logic signed [8:0] t_min;
    logic signed [8:0] t_max;

    logic [3:0]        reg_sel;
    logic              wr_ctrl;
    logic              wr_stat;
    logic              wr_thigh;
    logic              wr_tlow;

    logic              unused_bits;

    assign reg_sel  = addr_i[19:16];
    assign wr_ctrl  = we_i && (reg_sel == REG_CTRL);
    assign wr_stat  = we_i && (reg_sel == REG_STAT);
    assign wr_thigh = we_i && (reg_sel == REG_THIGH);
    assign wr_tlow  = we_i && (reg_sel == REG_TLOW);
    assign rise     = i2c_ready_i & ~ready_q;
    assign busy     = (state == S_REQ) || (state == S_BUSY) || (state == S_UPD);

    assign unused_bits = ^{addr_i[31:20], addr_i[15:0], data_i[31:9], i2c_data_i[6:0]};

    // Control register value after this cycle's bus write; a oneshot write in IDLE implies en.
    always_comb begin
        en_nx      = ctrl_en;
        oneshot_nx = ctrl_oneshot;
        int_en_nx  = ctrl_int_en;
        if (wr_ctrl) begin
            en_nx      = data_i[0];
            oneshot_nx = data_i[1];
            int_en_nx  = data_i[2];
            if (data_i[1] && (state == S_IDLE)) begin
                en_nx = 1'b1;
            end
        end
    end

    // Sequencer, register file, statistics and interrupt. Status sets are placed
    // after the W1C clears so that a set in the same cycle wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            cnt          <= '0;
            ready_q      <= 1'b0;
            i2c_req_o    <= 1'b0;
            int_o        <= 1'b0;
            ctrl_en      <= 1'b0;
            ctrl_oneshot <= 1'b0;
            ctrl_int_en  <= 1'b0;
            stat_alarm   <= 1'b0;
            stat_evt     <= 1'b0;
            stat_tmo     <= 1'b0;
            stat_valid   <= 1'b0;
            temp         <= '0;
            thigh        <= 9'h0A0;
            tlow         <= 9'h096;
            t_min        <= '0;
            t_max        <= '0;
        end else begin
            ready_q      <= i2c_ready_i;
            i2c_req_o    <= 1'b0;
            int_o        <= ctrl_int_en & (stat_evt | stat_tmo);
            ctrl_en      <= en_nx;
            ctrl_oneshot <= oneshot_nx;
            ctrl_int_en  <= int_en_nx;

            if (wr_thigh) begin
                thigh <= data_i[8:0];
            end
            if (wr_tlow) begin
                tlow <= data_i[8:0];
            end
            if (wr_stat) begin
                if (data_i[2]) stat_evt <= 1'b0;
                if (data_i[3]) stat_tmo <= 1'b0;
            end

            if (!en_nx) begin
                state <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE: begin
                        cnt   <= '0;
                        state <= S_WAIT;
                    end
                    S_WAIT: begin
                        if (cnt == PERIOD_CYCLES - 1) begin
                            i2c_req_o <= 1'b1;
                            state     <= S_REQ;
                        end else begin
                            cnt <= cnt + 32'd1;
                        end
                    end
                    S_REQ: begin
                        cnt   <= '0;
                        state <= S_BUSY;
                    end
                    S_BUSY: begin
                        if (rise) begin
                            temp  <= i2c_data_i[15:7];
                            state <= S_UPD;
                        end else if (cnt == TIMEOUT_CYCLES - 1) begin
                            stat_tmo <= 1'b1;
                            cnt      <= '0;
                            state    <= S_WAIT;
                        end else begin
                            cnt <= cnt + 32'd1;
                        end
                    end
                    S_UPD: begin
                        if (!stat_valid) begin
                            t_min <= temp;
                            t_max <= temp;
                        end else begin
                            if (temp < t_min) t_min <= temp;
                            if (temp > t_max) t_max <= temp;
                        end
                        stat_valid <= 1'b1;
                        if (temp > thigh) begin
                            stat_alarm <= 1'b1;
                            if (!stat_alarm) stat_evt <= 1'b1;
                        end else if (temp < tlow) begin
                            stat_alarm <= 1'b0;
                        end
                        if (ctrl_oneshot) begin
                            ctrl_en      <= 1'b0;
                            ctrl_oneshot <= 1'b0;
                            state        <= S_IDLE;
                        end else begin
                            cnt   <= '0;
                            state <= S_WAIT;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    // Register read mux; unmapped addresses read as zero.
    always_comb begin
        data_o = '0;
        case (reg_sel)
            REG_CTRL:  data_o = {29'd0, ctrl_int_en, ctrl_oneshot, ctrl_en};
            REG_STAT:  data_o = {27'd0, stat_valid, stat_tmo, stat_evt, stat_alarm, busy};
            REG_TEMP:  data_o = {{23{temp[8]}}, temp};
            REG_THIGH: data_o = {23'd0, thigh};
            REG_TLOW:  data_o = {23'd0, tlow};
            REG_MNMX:  data_o = {7'd0, t_max, 7'd0, t_min};
            default:   data_o = '0;
        endcase
    end

endmodule

// File: tb/tb_i2c_temp_monitor.sv
// Self-checking bench for i2c_temp_monitor: a scripted i2c responder feeds
// directed and random sensor words, and a behavioural model predicts the
// register contents.
module tb_i2c_temp_monitor;

    localparam int unsigned PERIOD  = 100;
    localparam int unsigned TIMEOUT = 200;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        we_i = 1'b0;
    logic [31:0] addr_i = '0;
    logic [31:0] data_i = '0;
    logic [31:0] data_o;
    logic        i2c_req_o;
    logic [15:0] i2c_data_i = '0;
    logic        i2c_ready_i = 1'b0;
    logic        int_o;

    i2c_temp_monitor #(
        .PERIOD_CYCLES (PERIOD),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .we_i       (we_i),
        .addr_i     (addr_i),
        .data_i     (data_i),
        .data_o     (data_o),
        .i2c_req_o  (i2c_req_o),
        .i2c_data_i (i2c_data_i),
        .i2c_ready_i(i2c_ready_i),
        .int_o      (int_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model
    int m_temp, m_min, m_max, m_thigh, m_tlow;
    bit m_valid, m_alarm, m_evt, m_tmo;

    // Responder controls and request monitor
    bit          resp_en   = 1'b1;
    int          resp_lat  = 50;
    logic [15:0] resp_word = '0;
    int          cyc = 0, req_count = 0, last_req_cyc = 0, last_gap = 0, wide = 0;
    bit          prev_req = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic int word2temp(input logic [15:0] w);
        int v;
        v = int'(w);
        if (v >= 32768) v -= 65536;
        return (v - ((v % 128 + 128) % 128)) / 128;   // floor(v / 128)
    endfunction

    function automatic logic [8:0] low9(input int v);
        logic [31:0] t;
        t = v;
        return t[8:0];
    endfunction

    function automatic void model_reset();
        m_temp = 0; m_min = 0; m_max = 0; m_thigh = 160; m_tlow = 150;
        m_valid = 0; m_alarm = 0; m_evt = 0; m_tmo = 0;
    endfunction

    function automatic void model_sample(input logic [15:0] w);
        m_temp = word2temp(w);
        if (!m_valid) begin
            m_min = m_temp; m_max = m_temp;
        end else begin
            if (m_temp < m_min) m_min = m_temp;
            if (m_temp > m_max) m_max = m_temp;
        end
        m_valid = 1;
        if (m_temp > m_thigh) begin
            if (!m_alarm) m_evt = 1;
            m_alarm = 1;
        end else if (m_temp < m_tlow) begin
            m_alarm = 0;
        end
    endfunction

    // Request monitor: counts pulses, measures spacing, flags pulses wider than one clock.
    always @(negedge clk) begin
        cyc++;
        if (rst_n && i2c_req_o) begin
            if (prev_req) wide++;
            else begin
                last_gap     = cyc - last_req_cyc;
                last_req_cyc = cyc;
                req_count++;
            end
        end
        prev_req = i2c_req_o;
    end

    // i2c master stand-in: answers each request after resp_lat clocks with a 3-clock ready.
    initial begin
        forever begin
            @(negedge clk);
            if (i2c_req_o && resp_en) begin
                repeat (resp_lat) @(negedge clk);
                i2c_data_i  = resp_word;
                i2c_ready_i = 1'b1;
                repeat (3) @(negedge clk);
                i2c_ready_i = 1'b0;
                i2c_data_i  = 16'($urandom);
            end
        end
    end

    task automatic wr(input logic [3:0] r, input logic [31:0] d);
        @(negedge clk);
        we_i   = 1'b1;
        addr_i = {12'h0, r, 16'h0};
        data_i = d;
        @(negedge clk);
        we_i   = 1'b0;
    endtask

    task automatic rd(input logic [3:0] r, output logic [31:0] v);
        @(negedge clk);
        addr_i = {12'h0, r, 16'h0};
        #1 v = data_o;
    endtask

    task automatic wait_req();
        int start, n;
        start = req_count;
        n = 0;
        while (req_count == start && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("req_seen", 32'(req_count != start), 32'd1);
    endtask

    function automatic logic [31:0] exp_stat_hi();
        return {27'd0, m_valid, m_tmo, m_evt, m_alarm, 1'b0};
    endfunction

    task automatic check_regs(input string tag);
        logic [31:0] v;
        rd(4'd3, v); check({tag, "_temp"}, v, 32'(m_temp));
        rd(4'd2, v); check({tag, "_stat"}, v & 32'h1E, exp_stat_hi());
        rd(4'd6, v); check({tag, "_mnmx"}, v, {7'd0, low9(m_max), 7'd0, low9(m_min)});
    endtask

    task automatic check_reset_values(input string tag);
        logic [31:0] v;
        rd(4'd1, v); check({tag, "_ctrl"}, v, 32'd0);
        rd(4'd2, v); check({tag, "_stat"}, v, 32'd0);
        rd(4'd3, v); check({tag, "_temp"}, v, 32'd0);
        rd(4'd4, v); check({tag, "_thigh"}, v, 32'h0A0);
        rd(4'd5, v); check({tag, "_tlow"}, v, 32'h096);
        rd(4'd6, v); check({tag, "_mnmx"}, v, 32'd0);
        rd(4'd0, v); check({tag, "_unmapped"}, v, 32'd0);
        check({tag, "_int"}, 32'(int_o), 32'd0);
        check({tag, "_req"}, 32'(i2c_req_o), 32'd0);
    endtask

    task automatic run_sample(input logic [15:0] w, input string tag, input bit chk_int);
        resp_word = w;
        wait_req();
        repeat (resp_lat + 6) @(negedge clk);
        model_sample(w);
        check_regs(tag);
        if (chk_int) check({tag, "_int"}, 32'(int_o), 32'(m_evt | m_tmo));
    endtask

    initial begin
        logic [31:0] v;
        logic [15:0] w;
        int n, rc;
        bit hit;

        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check_reset_values("rst");

        // Periodic sampling with directed words exercising the alarm hysteresis
        resp_en = 1; resp_lat = 50;
        resp_word = 16'h1900;
        wr(4'd1, 32'h1);
        run_sample(16'h1900, "s25", 0);
        run_sample(16'h5100, "s81", 0);
        check("gap", 32'(last_gap >= PERIOD + resp_lat && last_gap <= PERIOD + resp_lat + 5), 32'd1);
        check("int_masked", 32'(int_o), 32'd0);
        run_sample(16'h4B80, "s75p5", 0);
        run_sample(16'h4A80, "s74p5", 0);

        // Interrupt enable and alarm_evt W1C
        wr(4'd1, 32'h5);
        repeat (3) @(negedge clk);
        check("int_on", 32'(int_o), 32'(m_evt));
        wr(4'd2, 32'h4);
        m_evt = 0;
        repeat (3) @(negedge clk);
        check("int_off", 32'(int_o), 32'd0);
        rd(4'd2, v); check("evt_w1c", v & 32'h1E, exp_stat_hi());

        run_sample(16'hE700, "neg25", 1);
        for (int i = 0; i < 6; i++) begin
            run_sample(16'($urandom), "rand", 1);
            if (m_evt) begin
                wr(4'd2, 32'h4);
                m_evt = 0;
            end
        end

        // Timeout: responder silent
        wr(4'd1, 32'h0);
        repeat (80) @(negedge clk);
        resp_en = 0;
        wr(4'd1, 32'h1);
        wait_req();
        n = 0; hit = 0;
        while (!hit && n < 400) begin
            rd(4'd2, v);
            n++;
            hit = v[3];
        end
        check("tmo_latency", 32'(hit && n >= TIMEOUT - 5 && n <= TIMEOUT + 5), 32'd1);
        m_tmo = 1;
        rd(4'd3, v); check("tmo_temp_kept", v, 32'(m_temp));
        wait_req();
        check("tmo_regap", 32'(last_gap >= TIMEOUT + PERIOD - 1 && last_gap <= TIMEOUT + PERIOD + 3), 32'd1);
        wr(4'd2, 32'h8);
        m_tmo = 0;
        rd(4'd2, v); check("tmo_w1c", 32'(v[3]), 32'd0);
        wr(4'd1, 32'h0);
        repeat (5) @(negedge clk);
        rd(4'd2, v); check("tmo_idle", v & 32'h1F, exp_stat_hi());

        // Clear en while BUSY, then ready rises: must be ignored
        resp_en = 1; resp_lat = 30;
        do w = 16'($urandom); while (word2temp(w) == m_temp);
        resp_word = w;
        wr(4'd1, 32'h1);
        wait_req();
        repeat (5) @(negedge clk);
        wr(4'd1, 32'h0);
        repeat (40) @(negedge clk);
        rd(4'd3, v); check("dis_temp_kept", v, 32'(m_temp));
        rd(4'd2, v); check("dis_idle", v & 32'h1F, exp_stat_hi());
        rc = req_count;
        repeat (300) @(negedge clk);
        check("dis_no_req", 32'(req_count - rc), 32'd0);

        // Oneshot
        resp_lat = 20;
        w = 16'($urandom);
        resp_word = w;
        rc = req_count;
        wr(4'd1, 32'h2);
        repeat (400) @(negedge clk);
        model_sample(w);
        check("os_one_req", 32'(req_count - rc), 32'd1);
        rd(4'd1, v); check("os_ctrl", v, 32'd0);
        check_regs("os");

        // Reset mid-BUSY
        resp_lat = 40;
        wr(4'd1, 32'h1);
        wait_req();
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1 check("rst_req_async", 32'(i2c_req_o), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        check_reset_values("midrst");

        check("req_width", 32'(wide), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
